// File: rtl/axil_reg_slice.sv
// AXI4-Lite register slice: one two-entry skid buffer per channel (AW, W, AR forward; B, R return).
// Every valid, ready and payload signal on both sides comes straight from a flop.
module axil_reg_slice #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned AxW   = ADDR_WIDTH + 3;
  localparam int unsigned WW    = DATA_WIDTH + StrbW;
  localparam int unsigned BW    = 2;
  localparam int unsigned RW    = DATA_WIDTH + 2;
  localparam int unsigned TotW  = 2 * AxW + WW + BW + RW;

  // Channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R; payloads packed LSB-first in that order.
  function automatic int unsigned ch_width(input int unsigned c);
    case (c)
      0, 3:    return AxW;
      1:       return WW;
      2:       return BW;
      default: return RW;
    endcase
  endfunction

  function automatic int unsigned ch_off(input int unsigned c);
    int unsigned off;
    off = 0;
    for (int unsigned k = 0; k < c; k++) off += ch_width(k);
    return off;
  endfunction

  logic [4:0]      in_valid, in_ready, out_valid, out_ready;
  logic [TotW-1:0] in_pl, out_pl;

  assign in_valid  = {m_axi_rvalid, s_axi_arvalid, m_axi_bvalid, s_axi_wvalid, s_axi_awvalid};
  assign out_ready = {s_axi_rready, m_axi_arready, s_axi_bready, m_axi_wready, m_axi_awready};
  assign in_pl     = {m_axi_rdata, m_axi_rresp, s_axi_araddr, s_axi_arprot, m_axi_bresp,
                      s_axi_wdata, s_axi_wstrb, s_axi_awaddr, s_axi_awprot};

  for (genvar i = 0; i < 5; i++) begin : g_ch
    localparam int unsigned W = ch_width(i);
    localparam int unsigned O = ch_off(i);

    logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] out_pl_q, out_pl_d, skid_pl_q, skid_pl_d;
    logic         in_hs, out_hs;

    assign in_hs  = in_valid[i] & ~skid_valid_q;
    assign out_hs = out_valid_q & out_ready[i];

    always_comb begin
      out_valid_d  = out_valid_q;
      out_pl_d     = out_pl_q;
      skid_valid_d = skid_valid_q;
      skid_pl_d    = skid_pl_q;
      if (!out_valid_q || out_hs) begin
        // Skid beat is always older than anything arriving now.
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_pl_d     = skid_pl_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = in_hs;
          if (in_hs) out_pl_d = in_pl[O +: W];
        end
      end else if (in_hs) begin
        skid_valid_d = 1'b1;
        skid_pl_d    = in_pl[O +: W];
      end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
        out_valid_q  <= 1'b0;
        out_pl_q     <= '0;
        skid_valid_q <= 1'b0;
        skid_pl_q    <= '0;
      end else begin
        out_valid_q  <= out_valid_d;
        out_pl_q     <= out_pl_d;
        skid_valid_q <= skid_valid_d;
        skid_pl_q    <= skid_pl_d;
      end
    end

    assign in_ready[i]    = ~skid_valid_q;
    assign out_valid[i]   = out_valid_q;
    assign out_pl[O +: W] = out_pl_q;
  end

  assign s_axi_awready = in_ready[0];
  assign s_axi_wready  = in_ready[1];
  assign m_axi_bready  = in_ready[2];
  assign s_axi_arready = in_ready[3];
  assign m_axi_rready  = in_ready[4];

  assign m_axi_awvalid = out_valid[0];
  assign m_axi_wvalid  = out_valid[1];
  assign s_axi_bvalid  = out_valid[2];
  assign m_axi_arvalid = out_valid[3];
  assign s_axi_rvalid  = out_valid[4];

  assign {m_axi_awaddr, m_axi_awprot} = out_pl[ch_off(0) +: AxW];
  assign {m_axi_wdata, m_axi_wstrb}   = out_pl[ch_off(1) +: WW];
  assign s_axi_bresp                  = out_pl[ch_off(2) +: BW];
  assign {m_axi_araddr, m_axi_arprot} = out_pl[ch_off(3) +: AxW];
  assign {s_axi_rdata, s_axi_rresp}   = out_pl[ch_off(4) +: RW];

endmodule

// File: tb/tb_axil_reg_slice.sv
// Bench for axil_reg_slice: per-channel FIFO scoreboard plus directed latency/backpressure/reset
// checks and a randomized traffic phase with a reactive GPIO-side slave model.
module tb_axil_reg_slice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  s_awprot, s_arprot, m_awprot, m_arprot;
  logic [3:0]  s_wstrb, m_wstrb;
  logic [1:0]  s_bresp, s_rresp, m_bresp, m_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;

  axil_reg_slice #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(s_awaddr), .s_axi_awprot(s_awprot), .s_axi_awvalid(s_awvalid),
    .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arprot(s_arprot), .s_axi_arvalid(s_arvalid),
    .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_awaddr(m_awaddr), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arprot(m_arprot), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Scoreboard state; channel index 0 AW, 1 W, 2 B, 3 AR, 4 R.
  logic [63:0] sq0[$], sq1[$], sq2[$], sq3[$], sq4[$];
  logic [63:0] last_pl[5];
  logic [4:0]  stall = '0;
  logic [4:0]  hs_in = '0;
  logic [4:0]  hs_out = '0;
  int          out_cnt[5] = '{0, 0, 0, 0, 0};
  // Slave model and end-to-end read ordering.
  logic [31:0] slv_rq[$];
  logic [1:0]  slv_bq[$];
  logic [31:0] iss_ar[$];
  logic        e2e_en = 1'b0;
  int          r_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    failed++;
    $display("FAIL %s: unexpected beat", name);
  endtask

  function automatic logic [31:0] rfun(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  function automatic int sq_size(input int c);
    case (c)
      0: return sq0.size();
      1: return sq1.size();
      2: return sq2.size();
      3: return sq3.size();
      default: return sq4.size();
    endcase
  endfunction

  task automatic sq_push(input int c, input logic [63:0] v);
    case (c)
      0: sq0.push_back(v);
      1: sq1.push_back(v);
      2: sq2.push_back(v);
      3: sq3.push_back(v);
      default: sq4.push_back(v);
    endcase
  endtask

  task automatic sq_pop(input int c, output logic [63:0] v);
    case (c)
      0: v = sq0.pop_front();
      1: v = sq1.pop_front();
      2: v = sq2.pop_front();
      3: v = sq3.pop_front();
      default: v = sq4.pop_front();
    endcase
  endtask

  task automatic sb_chan(input int c, input logic iv, input logic ir, input logic [63:0] ipl,
                         input logic ov, input logic orr, input logic [63:0] opl);
    logic [63:0] e;
    hs_in[c]  = iv & ir;
    hs_out[c] = ov & orr;
    if (stall[c]) begin
      check($sformatf("stable_valid_ch%0d", c), {63'd0, ov}, 64'd1);
      check($sformatf("stable_pl_ch%0d", c), opl, last_pl[c]);
    end
    if (hs_out[c]) begin
      out_cnt[c]++;
      if (sq_size(c) == 0) fail_now($sformatf("dup_ch%0d", c));
      else begin
        sq_pop(c, e);
        check($sformatf("order_ch%0d", c), opl, e);
      end
    end
    if (hs_in[c]) sq_push(c, ipl);
    stall[c]   = ov & ~orr;
    last_pl[c] = opl;
  endtask

  // Monitor samples 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      sq0.delete(); sq1.delete(); sq2.delete(); sq3.delete(); sq4.delete();
      hs_in  = '0;
      hs_out = '0;
      stall  = '0;
    end else begin
      sb_chan(0, s_awvalid, s_awready, {29'd0, s_awaddr, s_awprot},
              m_awvalid, m_awready, {29'd0, m_awaddr, m_awprot});
      sb_chan(1, s_wvalid, s_wready, {28'd0, s_wdata, s_wstrb},
              m_wvalid, m_wready, {28'd0, m_wdata, m_wstrb});
      sb_chan(2, m_bvalid, m_bready, {62'd0, m_bresp}, s_bvalid, s_bready, {62'd0, s_bresp});
      sb_chan(3, s_arvalid, s_arready, {29'd0, s_araddr, s_arprot},
              m_arvalid, m_arready, {29'd0, m_araddr, m_arprot});
      sb_chan(4, m_rvalid, m_rready, {30'd0, m_rdata, m_rresp},
              s_rvalid, s_rready, {30'd0, s_rdata, s_rresp});
      if (hs_out[3]) slv_rq.push_back(rfun(m_araddr));
      if (hs_out[1]) slv_bq.push_back(2'($urandom_range(0, 3)));
      if (hs_out[4] && e2e_en) begin
        r_done++;
        if (iss_ar.size() == 0) fail_now("r_extra");
        else check("r_issue_order", {32'd0, s_rdata}, {32'd0, rfun(iss_ar.pop_front())});
      end
    end
  end

  initial begin
    int          idx, base, aw_sent, w_sent, ar_sent;
    logic [31:0] addrs[3];
    logic        done;

    rst_n = 1'b0;
    {s_awvalid, s_wvalid, s_arvalid, m_bvalid, m_rvalid} = '0;
    {s_awaddr, s_awprot, s_wdata, s_wstrb, s_araddr, s_arprot} = '0;
    {m_bresp, m_rdata, m_rresp} = '0;
    {m_awready, m_wready, m_arready, s_bready, s_rready} = 5'h1f;

    // Reset state.
    #2;
    check("rst_valids", {59'd0, m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}, 64'd0);
    check("rst_readies", {59'd0, s_awready, s_wready, m_bready, s_arready, m_rready}, 64'h1f);
    check("rst_awaddr", {32'd0, m_awaddr}, 64'd0);
    check("rst_wdata", {32'd0, m_wdata}, 64'd0);
    check("rst_araddr", {32'd0, m_araddr}, 64'd0);
    check("rst_rdata", {32'd0, s_rdata}, 64'd0);
    check("rst_small", {48'd0, s_bresp, s_rresp, m_awprot, m_arprot, m_wstrb, 2'b00}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_valids", {59'd0, m_awvalid, m_wvalid, s_bvalid, m_arvalid, s_rvalid}, 64'd0);
    end

    // Single write, one cycle latency each way.
    s_awaddr = 32'h4; s_awprot = 3'd0; s_awvalid = 1'b1;
    s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'hF; s_wvalid = 1'b1;
    check("wr_no_comb_aw", {63'd0, m_awvalid}, 64'd0);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("wr_awvalid", {63'd0, m_awvalid}, 64'd1);
    check("wr_awaddr", {32'd0, m_awaddr}, 64'h4);
    check("wr_wvalid", {63'd0, m_wvalid}, 64'd1);
    check("wr_wdata", {28'd0, m_wdata, m_wstrb}, {28'd0, 32'hA5A5_A5A5, 4'hF});
    @(negedge clk);
    check("wr_aw_drained", {63'd0, m_awvalid}, 64'd0);
    m_bresp = 2'd0; m_bvalid = 1'b1;
    check("b_no_comb", {63'd0, s_bvalid}, 64'd0);
    @(negedge clk);
    m_bvalid = 1'b0;
    check("b_valid", {63'd0, s_bvalid}, 64'd1);
    check("b_resp", {62'd0, s_bresp}, 64'd0);
    @(negedge clk);
    check("b_drained", {63'd0, s_bvalid}, 64'd0);

    // Three reads against a stalled slave.
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    idx = 0;
    base = out_cnt[3];
    m_arready = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (s_arvalid && hs_in[3]) begin
        idx++;
        s_arvalid = 1'b0;
      end
      if (cyc == 2) check("ar_ready_low_after_2", {63'd0, s_arready}, 64'd0);
      if (idx < 3) begin
        s_araddr = addrs[idx];
        s_arvalid = 1'b1;
      end
      m_arready = (cyc >= 4);
    end
    check("ar_all_accepted", 64'(idx), 64'd3);
    check("ar_all_emerged", 64'(out_cnt[3] - base), 64'd3);
    check("ar_sb_empty", 64'(sq_size(3)), 64'd0);

    // R stall with upstream not ready.
    s_rready = 1'b0;
    m_rdata = 32'h1234_5678; m_rresp = 2'd0; m_rvalid = 1'b1;
    @(negedge clk);
    m_rvalid = 1'b0;
    repeat (3) begin
      check("r_stall_valid", {63'd0, s_rvalid}, 64'd1);
      check("r_stall_data", {32'd0, s_rdata}, 64'h1234_5678);
      @(negedge clk);
    end
    base = out_cnt[4];
    s_rready = 1'b1;
    @(negedge clk);
    check("r_released", {63'd0, s_rvalid}, 64'd0);
    @(negedge clk);
    check("r_one_beat", 64'(out_cnt[4] - base), 64'd1);

    // Reset while the W buffer holds two beats.
    m_wready = 1'b0;
    s_wdata = 32'h1111_1111; s_wstrb = 4'hF; s_wvalid = 1'b1;
    @(negedge clk);
    s_wdata = 32'h2222_2222;
    @(negedge clk);
    s_wvalid = 1'b0;
    check("w_full_ready", {63'd0, s_wready}, 64'd0);
    check("w_full_valid", {63'd0, m_wvalid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wvalid", {63'd0, m_wvalid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_wready", {63'd0, s_wready}, 64'd1);
    m_wready = 1'b1;
    s_wdata = 32'h3333_3333; s_wstrb = 4'h3; s_wvalid = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    check("post_rst_wvalid", {63'd0, m_wvalid}, 64'd1);
    check("post_rst_wdata", {28'd0, m_wdata, m_wstrb}, {28'd0, 32'h3333_3333, 4'h3});
    @(negedge clk);
    check("post_rst_w_drained", {63'd0, m_wvalid}, 64'd0);

    // Randomized traffic on all channels, reactive slave.
    slv_rq.delete(); slv_bq.delete(); iss_ar.delete();
    e2e_en = 1'b1;
    aw_sent = 0; w_sent = 0; ar_sent = 0;
    base = out_cnt[2];
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (s_awvalid && hs_in[0]) s_awvalid = 1'b0;
      if (!s_awvalid && aw_sent < 12 && $urandom_range(0, 3) != 0) begin
        s_awaddr = $urandom & 32'hFFFF_FFFC; s_awprot = 3'($urandom_range(0, 7));
        s_awvalid = 1'b1; aw_sent++;
      end
      if (s_wvalid && hs_in[1]) s_wvalid = 1'b0;
      if (!s_wvalid && w_sent < 12 && $urandom_range(0, 3) != 0) begin
        s_wdata = $urandom; s_wstrb = 4'($urandom_range(0, 15));
        s_wvalid = 1'b1; w_sent++;
      end
      if (s_arvalid && hs_in[3]) s_arvalid = 1'b0;
      if (!s_arvalid && ar_sent < 16 && $urandom_range(0, 3) != 0) begin
        s_araddr = $urandom & 32'hFFFF_FFFC; s_arprot = 3'($urandom_range(0, 7));
        iss_ar.push_back(s_araddr);
        s_arvalid = 1'b1; ar_sent++;
      end
      if (m_bvalid && hs_in[2]) m_bvalid = 1'b0;
      if (!m_bvalid && slv_bq.size() > 0 && $urandom_range(0, 1) != 0) begin
        m_bresp = slv_bq.pop_front(); m_bvalid = 1'b1;
      end
      if (m_rvalid && hs_in[4]) m_rvalid = 1'b0;
      if (!m_rvalid && slv_rq.size() > 0 && $urandom_range(0, 1) != 0) begin
        m_rdata = slv_rq.pop_front(); m_rresp = 2'($urandom_range(0, 3)); m_rvalid = 1'b1;
      end
      m_awready = 1'($urandom_range(0, 1));
      m_wready  = 1'($urandom_range(0, 1));
      m_arready = 1'($urandom_range(0, 1));
      s_bready  = 1'($urandom_range(0, 1));
      s_rready  = 1'($urandom_range(0, 1));
      done = (aw_sent == 12) && (w_sent == 12) && (ar_sent == 16) && (r_done == 16) &&
             (out_cnt[2] - base == 12) && !s_awvalid && !s_wvalid && !s_arvalid &&
             !m_bvalid && !m_rvalid && (slv_rq.size() == 0) && (slv_bq.size() == 0) &&
             (sq_size(0) + sq_size(1) + sq_size(2) + sq_size(3) + sq_size(4) == 0);
    end
    check("rand_r_count", 64'(r_done), 64'd16);
    check("rand_b_count", 64'(out_cnt[2] - base), 64'd12);
    check("rand_sb_empty",
          64'(sq_size(0) + sq_size(1) + sq_size(2) + sq_size(3) + sq_size(4)), 64'd0);
    check("rand_no_pending_ar", 64'(iss_ar.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axil_reg_slice.md
# axil_reg_slice

AXI4-Lite register slice that sits directly upstream of the GPIO AXI4-Lite slave, between the system interconnect and the `gpio_axi` port. It registers every forward signal (AW, W, AR) and every return signal (B, R) through an independent two-entry skid buffer per channel. This breaks all combinational valid/ready/data paths between the interconnect and the peripheral at full throughput. It adds exactly one cycle of latency per channel direction.

## Interface
- ADDR_WIDTH, 32, address width of AW/AR channels
- DATA_WIDTH, 32, data width of W/R channels; strobe width is DATA_WIDTH/8
- s_axi_aclk  in  1  single clock for both sides
- s_axi_aresetn  in  1  asynchronous, active-low reset
- s_axi_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  upstream write address; s_axi_awready out 1
- s_axi_wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1  upstream write data; s_axi_wready out 1
- s_axi_bresp/bvalid  out  2/1  upstream write response; s_axi_bready in 1
- s_axi_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  upstream read address; s_axi_arready out 1
- s_axi_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  upstream read data; s_axi_rready in 1
- m_axi_awaddr/awprot/awvalid  out  ADDR_WIDTH/3/1  to GPIO slave; m_axi_awready in 1
- m_axi_wdata/wstrb/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1  to GPIO slave; m_axi_wready in 1
- m_axi_bresp/bvalid  in  2/1  from GPIO slave; m_axi_bready out 1
- m_axi_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  to GPIO slave; m_axi_arready in 1
- m_axi_rdata/rresp/rvalid  in  DATA_WIDTH/2/1  from GPIO slave; m_axi_rready out 1

## Operation
- Five identical skid-buffer instances, one per channel.
  - AW, W and AR run s→m.
  - B and R run m→s.
- Each buffer has an output register (out_valid, out_payload) and a skid register (skid_valid, skid_payload). Payload is the full channel bundle.
- Input ready = !skid_valid, driven from a flop. Never combinational from downstream ready.
- Per-cycle update, with in_hs = in_valid & in_ready and out_hs = out_valid & out_ready:
  - Output empty, or out_hs: load output from the skid register if skid_valid, else from the input if in_hs. out_valid follows the source.
  - Output full, no out_hs, and in_hs: capture the input into the skid register and set skid_valid.
  - skid_valid clears when its contents move to the output.
- States per buffer: EMPTY (0 held), ONE (output only), FULL (output+skid, input ready low).
  - EMPTY→ONE on in_hs.
  - ONE→EMPTY on out_hs without in_hs.
  - ONE→FULL on in_hs without out_hs.
  - ONE stays ONE on both handshakes.
  - FULL→ONE on out_hs; in_hs is impossible in FULL.
- Order preserved per channel. No beat is dropped, duplicated or reordered.
- Channels are fully independent. AW and W may reach the slave in different cycles; the GPIO slave waits for both.
- Payload (addr, prot, data, strb, resp) passes unmodified. No response is generated locally.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all *valid outputs 0;
  - all data/addr/prot/strb/resp outputs 0;
  - all *ready outputs 1.
- Latency: a beat accepted at edge N is presented on the far side after edge N, i.e. valid on the following cycle. One cycle per direction.
- Write round trip adds 2 cycles: 1 on AW/W plus 1 on B. Read round trip likewise adds 2 cycles: 1 on AR plus 1 on R.
- Throughput: one beat per cycle per channel while downstream ready stays high.
- Backpressure: with downstream ready low, the buffer accepts at most 2 beats. Input ready drops in the cycle after the second accept.
- Stable-payload rule: while out_valid=1 and out_ready=0, the output payload must not change.
- Reset mid-transfer: all buffered beats are discarded and every valid output returns to 0 immediately. Reset release is synchronous to s_axi_aclk.

## Test plan
- Reset, then idle:
  - during reset, all *valid=0 and all *ready=1;
  - no valid output rises without an input beat.
- Single write, AW=0x0000_0004 and W=0xA5A5_A5A5 with wstrb=0xF presented together, m ready high:
  - m_awvalid and m_wvalid rise 1 cycle after the s handshake with identical payloads;
  - m_bresp=0 is returned on s_bvalid 1 cycle after m_bvalid.
- Back-to-back reads to 0x0, 0x4, 0x8 with m_arready held low for 4 cycles:
  - s_arready is low after 2 accepts;
  - all three addresses emerge in order once m_arready goes high;
  - no address is lost.
- R-channel stall, slave returns rdata=0x1234_5678 while s_rready=0 for 3 cycles:
  - s_rdata is held stable;
  - exactly one beat is delivered when s_rready=1.
- Streaming 16 AR beats with random m_arready/s_rready:
  - R data order matches issue order;
  - zero duplicates.
- Reset asserted with the skid registers full on W:
  - m_wvalid drops to 0 immediately;
  - after release, s_wready=1 and the next write passes cleanly.
